// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide engine feeding the register-file write port.
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start, funct3       begin an M-extension op (sampled only while idle)
//   operandA, operandB  rs1 / rs2 values, latched on start
//   rdIn, rdOut         destination register in / latched out
//   busy                op in progress, core holds the PC
//   done, regWrite      one-cycle completion strobe / done && rdOut != 0
//   result              final value, held until the next done
//   MULDIV_FAST_MUL_EN  when defined, MUL* use a single-cycle 33x33 signed multiply
module mul_div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] operandA,
    input  logic [DATA_WIDTH-1:0] operandB,
    input  logic [ADDR_WIDTH-1:0] rdIn,
    output logic                  busy,
    output logic                  done,
    output logic                  regWrite,
    output logic [DATA_WIDTH-1:0] result,
    output logic [ADDR_WIDTH-1:0] rdOut
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} stateT;
    stateT state, nextState;

    logic [2:0]            op;
    logic [ADDR_WIDTH-1:0] rdLatch;
    logic [4:0]            count;
    logic                  special, negFlag;
    logic [W-1:0]          mag;
    logic [2*W-1:0]        acc;

    logic         signedA, signedB, aNeg, bNeg, divZero, divOvf, isSpecial, qBit, isRem;
    logic [W-1:0] absA, absB, specialVal, divWord, divFix, fixVal;
    logic [W:0]   mulSum, remCand, divDiff;
    logic [2*W-1:0] mulNext, divNext, prodFix;

    // Signedness of each operand as selected by funct3 (MUL low word is sign-agnostic).
    assign signedA    = funct3[2] ? !funct3[0] : ^funct3[1:0];
    assign signedB    = funct3[2] ? !funct3[0] : (funct3[1:0] == 2'b01);
    assign aNeg       = signedA & operandA[W-1];
    assign bNeg       = signedB & operandB[W-1];
    assign absA       = aNeg ? -operandA : operandA;
    assign absB       = bNeg ? -operandB : operandB;
    assign divZero    = funct3[2] && operandB == '0;
    assign divOvf     = funct3[2] && !funct3[0] && operandA == {1'b1, {(W-1){1'b0}}} && operandB == '1;
    assign isSpecial  = divZero | divOvf;
    // Overflow case: quotient equals the dividend (0x80000000), remainder is zero.
    assign specialVal = divZero ? (funct3[1] ? operandA : '1) : (funct3[1] ? '0 : operandA);

    // Shift-add step: acc = {partial product high, remaining multiplier bits}.
    assign mulSum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag} : '0);
    assign mulNext = {mulSum, acc[W-1:1]};
    // Restoring step: acc = {partial remainder, dividend bits shifting into quotient}.
    assign remCand = acc[2*W-1:W-1];
    assign divDiff = remCand - {1'b0, mag};
    assign qBit    = !divDiff[W];
    assign divNext = {qBit ? divDiff[W-1:0] : remCand[W-1:0], acc[W-2:0], qBit};

    assign isRem   = op[2] & op[1];
    assign prodFix = negFlag ? -acc : acc;
    assign divWord = isRem ? acc[2*W-1:W] : acc[W-1:0];
    assign divFix  = negFlag ? -divWord : divWord;
    assign fixVal  = special ? acc[W-1:0] :
                     op[2] ? divFix :
                     (op[1:0] == 2'b00) ? prodFix[W-1:0] : prodFix[2*W-1:W];

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*W+1:0] fastProd;
    assign fastProd = $signed({signedA & operandA[W-1], operandA}) * $signed({signedB & operandB[W-1], operandB});
`endif

    assign busy = state != IDLE;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (start) nextState = isSpecial ? FIX : (funct3[2] ? DIV : MUL);
`ifdef MULDIV_FAST_MUL_EN
            MUL:  nextState = FIX;
`else
            MUL:  if (count == '1) nextState = FIX;
`endif
            DIV:  if (count == '1) nextState = FIX;
            FIX:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op       <= '0;
            rdLatch  <= '0;
            count    <= '0;
            special  <= 1'b0;
            negFlag  <= 1'b0;
            mag      <= '0;
            acc      <= '0;
            done     <= 1'b0;
            regWrite <= 1'b0;
            result   <= '0;
            rdOut    <= '0;
        end else begin
            done     <= state == FIX;
            regWrite <= state == FIX && rdLatch != '0;
            case (state)
                IDLE: if (start) begin
                    op      <= funct3;
                    rdLatch <= rdIn;
                    count   <= '0;
                    special <= isSpecial;
                    negFlag <= isRem ? 1'b0 : 1'b0;
                    negFlag <= (funct3[2] & funct3[1]) ? aNeg : aNeg ^ bNeg;
                    mag     <= funct3[2] ? absB : absA;
                    acc     <= isSpecial ? {{W{1'b0}}, specialVal} : {{W{1'b0}}, funct3[2] ? absA : absB};
`ifdef MULDIV_FAST_MUL_EN
                    if (!funct3[2]) begin
                        negFlag <= 1'b0;
                        acc     <= fastProd[2*W-1:0];
                    end
`endif
                end
`ifdef MULDIV_FAST_MUL_EN
                MUL: count <= count;
`else
                MUL: begin
                    acc   <= mulNext;
                    count <= count + 5'd1;
                end
`endif
                DIV: begin
                    acc   <= divNext;
                    count <= count + 5'd1;
                end
                FIX: begin
                    result <= fixVal;
                    rdOut  <= rdLatch;
                end
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;
    logic        clock = 1'b0;
    logic        reset, start;
    logic [2:0]  funct3;
    logic [31:0] operandA, operandB, result;
    logic [4:0]  rdIn, rdOut;
    logic        busy, done, regWrite;
    int passed = 0, total = 0;

    always #5 clock = ~clock;

    mul_div_unit dut (
        .clock(clock), .reset(reset), .start(start), .funct3(funct3),
        .operandA(operandA), .operandB(operandB), .rdIn(rdIn),
        .busy(busy), .done(done), .regWrite(regWrite), .result(result), .rdOut(rdOut)
    );

    // Issues one op, scrambles the inputs after E0, and waits (bounded) for done.
    task automatic runOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         output logic [31:0] res, output int lat, output logic rw, output logic [4:0] ro, output logic bz);
        @(negedge clock);
        start = 1'b1; funct3 = f; operandA = a; operandB = b; rdIn = rd;
        @(posedge clock); #1;
        start = 1'b0; funct3 = 3'b000; operandA = 32'hDEADBEEF; operandB = 32'h0; rdIn = 5'd31;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clock); #1;
            if (done) begin lat = i; break; end
        end
        res = result; rw = regWrite; ro = rdOut; bz = busy;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; funct3 = 3'b000; operandA = '0; operandB = '0; rdIn = '0;
        repeat (3) @(posedge clock);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
        total++; if (regWrite !== 1'b0) $display("FAIL reset_regWrite: got %b want 0", regWrite); else passed++;
        total++; if (result !== 32'h0) $display("FAIL reset_result: got %h want 0", result); else passed++;
        total++; if (rdOut !== 5'd0) $display("FAIL reset_rdOut: got %0d want 0", rdOut); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_mul;
        logic [31:0] r; int l; logic rw, bz; logic [4:0] ro;
        runOp(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, r, l, rw, ro, bz);
        total++; if (r !== 32'hFFFFFFEB) $display("FAIL mul_result: got %h want FFFFFFEB", r); else passed++;
        total++; if (l !== 33) $display("FAIL mul_latency: got %0d want 33", l); else passed++;
        total++; if (rw !== 1'b1) $display("FAIL mul_regWrite: got %b want 1", rw); else passed++;
        total++; if (ro !== 5'd5) $display("FAIL mul_rdOut: got %0d want 5", ro); else passed++;
        total++; if (bz !== 1'b0) $display("FAIL mul_busy_at_done: got %b want 0", bz); else passed++;
        runOp(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, r, l, rw, ro, bz);
        total++; if (r !== 32'hFFFFFFFE) $display("FAIL mulhu: got %h want FFFFFFFE", r); else passed++;
        runOp(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, r, l, rw, ro, bz);
        total++; if (r !== 32'h0) $display("FAIL mulh: got %h want 00000000", r); else passed++;
        runOp(3'b010, 32'hFFFFFFFF, 32'd2, 5'd1, r, l, rw, ro, bz);
        total++; if (r !== 32'hFFFFFFFF) $display("FAIL mulhsu: got %h want FFFFFFFF", r); else passed++;
    endtask

    task automatic test_div;
        logic [31:0] r; int l; logic rw, bz; logic [4:0] ro;
        runOp(3'b100, 32'hFFFFFFF9, 32'd2, 5'd3, r, l, rw, ro, bz);
        total++; if (r !== 32'hFFFFFFFD) $display("FAIL div: got %h want FFFFFFFD", r); else passed++;
        total++; if (l !== 33) $display("FAIL div_latency: got %0d want 33", l); else passed++;
        runOp(3'b110, 32'hFFFFFFF9, 32'd2, 5'd3, r, l, rw, ro, bz);
        total++; if (r !== 32'hFFFFFFFF) $display("FAIL rem: got %h want FFFFFFFF", r); else passed++;
        runOp(3'b101, 32'd100, 32'd7, 5'd3, r, l, rw, ro, bz);
        total++; if (r !== 32'd14) $display("FAIL divu: got %h want 0000000e", r); else passed++;
        runOp(3'b111, 32'd100, 32'd7, 5'd3, r, l, rw, ro, bz);
        total++; if (r !== 32'd2) $display("FAIL remu: got %h want 00000002", r); else passed++;
    endtask

    task automatic test_special;
        logic [31:0] r; int l; logic rw, bz; logic [4:0] ro;
        runOp(3'b101, 32'd5, 32'd0, 5'd4, r, l, rw, ro, bz);
        total++; if (r !== 32'hFFFFFFFF) $display("FAIL divu_by_zero: got %h want FFFFFFFF", r); else passed++;
        total++; if (l !== 1) $display("FAIL special_latency: got %0d want 1", l); else passed++;
        runOp(3'b110, 32'd5, 32'd0, 5'd4, r, l, rw, ro, bz);
        total++; if (r !== 32'd5) $display("FAIL rem_by_zero: got %h want 00000005", r); else passed++;
        runOp(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd4, r, l, rw, ro, bz);
        total++; if (r !== 32'h80000000) $display("FAIL div_overflow: got %h want 80000000", r); else passed++;
        runOp(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd4, r, l, rw, ro, bz);
        total++; if (r !== 32'h0) $display("FAIL rem_overflow: got %h want 00000000", r); else passed++;
    endtask

    task automatic test_ignore_start;
        int dones = 0, firstAt = -1;
        logic busyAt10 = 1'b0;
        @(negedge clock);
        start = 1'b1; funct3 = 3'b000; operandA = 32'd7; operandB = 32'hFFFFFFFD; rdIn = 5'd6;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            if (i == 10) begin start = 1'b1; funct3 = 3'b101; operandA = 32'd100; operandB = 32'd7; end
            @(posedge clock); #1;
            if (i == 10) begin start = 1'b0; busyAt10 = busy; end
            if (done) begin dones++; if (firstAt < 0) firstAt = i; end
        end
        total++; if (busyAt10 !== 1'b1) $display("FAIL ignore_busy: got %b want 1", busyAt10); else passed++;
        total++; if (dones != 1) $display("FAIL ignore_done_count: got %0d want 1", dones); else passed++;
        total++; if (firstAt != 33) $display("FAIL ignore_done_at: got %0d want 33", firstAt); else passed++;
        total++; if (result !== 32'hFFFFFFEB) $display("FAIL ignore_result: got %h want FFFFFFEB", result); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] r; int l = -1; logic rw, bz; logic [4:0] ro;
        runOp(3'b111, 32'd100, 32'd7, 5'd8, r, l, rw, ro, bz);
        total++; if (done !== 1'b1) $display("FAIL b2b_first_done: got %b want 1", done); else passed++;
        start = 1'b1; funct3 = 3'b101; operandA = 32'd100; operandB = 32'd7; rdIn = 5'd9;
        @(posedge clock); #1;
        start = 1'b0;
        l = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clock); #1;
            if (done) begin l = i; break; end
        end
        total++; if (l != 33) $display("FAIL b2b_latency: got %0d want 33", l); else passed++;
        total++; if (result !== 32'd14) $display("FAIL b2b_result: got %h want 0000000e", result); else passed++;
        total++; if (rdOut !== 5'd9) $display("FAIL b2b_rdOut: got %0d want 9", rdOut); else passed++;
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        @(negedge clock);
        start = 1'b1; funct3 = 3'b100; operandA = 32'hFFFFFFF9; operandB = 32'd2; rdIn = 5'd2;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (15) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        total++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL midreset_done: got %b want 0", done); else passed++;
        total++; if (result !== 32'h0) $display("FAIL midreset_result: got %h want 0", result); else passed++;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (done) dones++;
        end
        total++; if (dones != 0) $display("FAIL midreset_no_done: got %0d want 0", dones); else passed++;
    endtask

    task automatic test_rd_zero;
        logic [31:0] r; int l; logic rw, bz; logic [4:0] ro;
        runOp(3'b000, 32'd3, 32'd4, 5'd0, r, l, rw, ro, bz);
        total++; if (l != 33) $display("FAIL rd0_done_latency: got %0d want 33", l); else passed++;
        total++; if (rw !== 1'b0) $display("FAIL rd0_regWrite: got %b want 0", rw); else passed++;
        total++; if (r !== 32'd12) $display("FAIL rd0_result: got %h want 0000000c", r); else passed++;
    endtask

    initial begin
        test_reset;
        test_mul;
        test_div;
        test_special;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        test_rd_zero;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
